uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
Parametrised successor to the team's basic oversampling UART receiver.
- Adds a 2-flop input synchroniser, 3-sample majority voting, and false-start rejection.
- Adds runtime-selectable parity (none/even/odd) and 1 or 2 stop bits.
- Reports parity, framing and break errors.
- Sits between the shared baud-tick generator and the RX FIFO/host interface.

Parameters:
- DBITS, 8, data bits per frame; legal 5..9.
- OVERSAMPLE, 16, s_tick pulses per bit; even, legal 8..32.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line; idles high.
- s_tick  input  1  one-clk oversample strobe, OVERSAMPLE per bit period.
- cfg_parity  input  2  00 none, 01 even, 10 odd, 11 treated as none.
- cfg_stop2  input  1  0 one stop bit, 1 two stop bits.
- rx_dout  output  DBITS  received word; LSB is the first data bit.
- rx_done_tick  output  1  one-clk pulse marking a completed frame.
- parity_err  output  1  parity mismatch on the last frame.
- frame_err  output  1  a voted stop bit was 0 on the last frame.
- break_det  output  1  break condition on the last frame.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE; the synchroniser loads 1s.
  - All counters are cleared.
  - rx_dout is 0; rx_done_tick, parity_err, frame_err and break_det are 0.
  - Reset mid-frame abandons the frame with no done pulse.
- Synchroniser: rx passes through two flops to give rxs. All decisions use rxs, so there are 2 clk of input latency.
- Sample counter s (width $clog2(OVERSAMPLE)):
  - Increments only on s_tick and wraps from OVERSAMPLE-1 to 0.
  - Within each bit, rxs is captured on the s_tick where s equals H-1, H and H+1, with H = OVERSAMPLE/2.
  - The bit value is the majority of these three samples.
- States and transitions:
  - IDLE: a falling edge on rxs (previous 1, current 0) clears s, latches cfg_parity and cfg_stop2, and moves to START. Config changes mid-frame are ignored.
  - START: voted on the H+1 sample.
    - Vote = 1: false start; return to IDLE with no pulse and no error.
    - Vote = 0: continue to s = OVERSAMPLE-1, then clear s and the bit count n, and move to DATA.
  - DATA: each voted bit shifts into the MSB of the shift register (right shift).
    - At s = OVERSAMPLE-1: if n = DBITS-1, go to PARITY (parity enabled) or STOP; otherwise n is incremented.
  - PARITY: computed parity = XOR of the data bits, XORed with 1 for odd parity. A mismatch with the voted bit sets the pending parity error.
  - STOP: one or two stop bits.
    - First stop bit of a 2-stop frame: voted, then run to s = OVERSAMPLE-1.
    - Final stop bit: decided on the H+1 sample. The FSM does not wait for the bit to end, so a start edge immediately after a shortened stop bit is still caught.
    - Any voted stop bit of 0 sets frame_err.
  - BREAK_WAIT: entered when a break is detected; rx_done_tick is suppressed.
- Break: data all 0, parity bit 0 or absent, and the final stop bit 0.
  - break_det is set and frame_err is also set.
  - The FSM stays in BREAK_WAIT until rxs = 1, then moves to IDLE.
- Completion, on the final-stop decision cycle:
  - rx_done_tick = 1 for exactly one clk; the state is IDLE on the next clk.
  - rx_dout, parity_err, frame_err and break_det update in the same cycle and hold until the next completion or break.
  - A break updates the error flags without a done pulse.
  - Outputs are registered.
- Frame latency: from the rx falling edge to rx_done_tick = 2 clk (synchroniser) + (1 + DBITS + P + S - 1) × OVERSAMPLE + H + 2 s_ticks (approx.), where P is 1 if parity is enabled and S is the stop-bit count.
- Simultaneous events:
  - An s_tick on the same clk as the IDLE falling edge is not counted.
  - reset has priority over everything.
- Gaps in s_tick: no s_tick means no progress; the FSM never times out.

Test Plan:
1. 8N1, OVERSAMPLE=16: send 0x55 -> rx_dout=0x55; one rx_done_tick; parity_err=frame_err=break_det=0.
2. Even parity: send 0xA3 with parity bit 1 -> rx_dout=0xA3 with parity_err=1. Repeat with parity bit 0 -> parity_err=0. Odd mode with 0xA3 and parity bit 1 -> parity_err=0.
3. Glitch: rx low for 4 s_ticks then high -> FSM back to IDLE; no rx_done_tick; no error flags set.
4. Single-sample noise: invert rx at sample H in each data bit of 0x3C -> rx_dout=0x3C (majority vote recovers it).
5. Framing and break:
   - 0x81 with stop=0 -> frame_err=1, rx_done_tick pulses.
   - All-zero frame plus low stop -> break_det=1, frame_err=1, no done pulse.
   - Line held low 5 bit times then high -> return to IDLE; the next frame 0x12 decodes cleanly.
6. Back-to-back 2-stop frames 0xF0 then 0x0F, the second start edge at the end of the last stop bit -> two done pulses, correct data. Assert reset mid-DATA -> all outputs 0 next clk, no pulse.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver: 2-flop synchroniser, 3-sample majority vote, false-start
// rejection, runtime parity/stop-bit selection, parity/framing/break reporting.
module uart_rx_cfg #(
    parameter int DBITS      = 8,   // 5..9
    parameter int OVERSAMPLE = 16   // even, 8..32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    input  logic             s_tick,
    input  logic [1:0]       cfg_parity,
    input  logic             cfg_stop2,
    output logic [DBITS-1:0] rx_dout,
    output logic             rx_done_tick,
    output logic             parity_err,
    output logic             frame_err,
    output logic             break_det
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int NW = $clog2(DBITS);

    localparam logic [SW-1:0] S_LO   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_HI   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } state_t;

    state_t           state;
    logic             rx_meta;
    logic             rxs;
    logic             rxs_d;
    logic [SW-1:0]    s;
    logic [NW-1:0]    n;
    logic [DBITS-1:0] shreg;
    logic [1:0]       smp;
    logic             par_en;
    logic             par_odd;
    logic             stop2;
    logic             stop_first;
    logic             par_bit;
    logic             pe_pend;
    logic             fe_pend;

    logic             vote;
    logic             at_hi;
    logic             at_last;
    logic             brk;
    logic [SW-1:0]    s_next;

    // Third sample is the live rxs on the H+1 tick, so the vote is ready on that same cycle.
    assign vote    = (smp[0] & smp[1]) | (smp[0] & rxs) | (smp[1] & rxs);
    assign at_hi   = (s == S_HI);
    assign at_last = (s == S_LAST);
    assign s_next  = at_last ? '0 : s + 1'b1;
    // par_bit stays 0 when parity is disabled, so an absent parity bit counts as low.
    assign brk     = (shreg == '0) && !par_bit && !vote;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta      <= 1'b1;
            rxs          <= 1'b1;
            rxs_d        <= 1'b1;
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            shreg        <= '0;
            smp          <= '0;
            par_en       <= 1'b0;
            par_odd      <= 1'b0;
            stop2        <= 1'b0;
            stop_first   <= 1'b0;
            par_bit      <= 1'b0;
            pe_pend      <= 1'b0;
            fe_pend      <= 1'b0;
            rx_dout      <= '0;
            rx_done_tick <= 1'b0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
            break_det    <= 1'b0;
        end else begin
            rx_meta      <= rx;
            rxs          <= rx_meta;
            rxs_d        <= rxs;
            rx_done_tick <= 1'b0;

            if (s_tick) begin
                if (s == S_LO)  smp[0] <= rxs;
                if (s == S_MID) smp[1] <= rxs;
            end

            case (state)
                IDLE: begin
                    if (rxs_d && !rxs) begin
                        state   <= START;
                        s       <= '0;
                        par_en  <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
                        par_odd <= (cfg_parity == 2'b10);
                        stop2   <= cfg_stop2;
                        par_bit <= 1'b0;
                        pe_pend <= 1'b0;
                        fe_pend <= 1'b0;
                    end
                end

                START: begin
                    if (s_tick) begin
                        if (at_hi && vote) begin
                            state <= IDLE;
                            s     <= '0;
                        end else if (at_last) begin
                            s     <= '0;
                            n     <= '0;
                            state <= DATA;
                        end else begin
                            s <= s_next;
                        end
                    end
                end

                DATA: begin
                    if (s_tick) begin
                        if (at_hi)
                            shreg <= {vote, shreg[DBITS-1:1]};
                        if (at_last) begin
                            s <= '0;
                            if (n == N_LAST) begin
                                n          <= '0;
                                stop_first <= stop2;
                                state      <= par_en ? PARITY : STOP;
                            end else begin
                                n <= n + 1'b1;
                            end
                        end else begin
                            s <= s_next;
                        end
                    end
                end

                PARITY: begin
                    if (s_tick) begin
                        if (at_hi) begin
                            par_bit <= vote;
                            pe_pend <= (^shreg) ^ par_odd ^ vote;
                        end
                        if (at_last) begin
                            s     <= '0;
                            state <= STOP;
                        end else begin
                            s <= s_next;
                        end
                    end
                end

                STOP: begin
                    if (s_tick) begin
                        if (stop_first) begin
                            if (at_hi && !vote)
                                fe_pend <= 1'b1;
                            if (at_last) begin
                                s          <= '0;
                                stop_first <= 1'b0;
                            end else begin
                                s <= s_next;
                            end
                        end else if (at_hi) begin
                            // Decide mid-bit so a start edge right after a short stop bit is caught.
                            s          <= '0;
                            rx_dout    <= shreg;
                            parity_err <= pe_pend;
                            frame_err  <= fe_pend | ~vote;
                            if (brk) begin
                                break_det <= 1'b1;
                                state     <= BREAK_WAIT;
                            end else begin
                                break_det    <= 1'b0;
                                rx_done_tick <= 1'b1;
                                state        <= IDLE;
                            end
                        end else begin
                            s <= s_next;
                        end
                    end
                end

                BREAK_WAIT: begin
                    if (rxs)
                        state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: frames built bit-slot by bit-slot, expected results derived from
// the frame contents, checked every cycle plus literal spot checks.
module tb_uart_rx_cfg;

    localparam int D  = 8;
    localparam int OS = 16;

    logic         clk        = 1'b0;
    logic         reset      = 1'b1;
    logic         rx         = 1'b1;
    logic         s_tick     = 1'b0;
    logic [1:0]   cfg_parity = 2'b00;
    logic         cfg_stop2  = 1'b0;
    logic [D-1:0] rx_dout;
    logic         rx_done_tick;
    logic         parity_err;
    logic         frame_err;
    logic         break_det;

    uart_rx_cfg #(.DBITS(D), .OVERSAMPLE(OS)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .s_tick       (s_tick),
        .cfg_parity   (cfg_parity),
        .cfg_stop2    (cfg_stop2),
        .rx_dout      (rx_dout),
        .rx_done_tick (rx_done_tick),
        .parity_err   (parity_err),
        .frame_err    (frame_err),
        .break_det    (break_det)
    );

    always #5 clk = ~clk;

    int          errors   = 0;
    int          checks   = 0;
    int unsigned tick_no  = 0;
    int unsigned dec_tick = 0;
    int unsigned done_cnt = 0;
    bit          chk_en    = 1'b0;
    bit          dec_armed = 1'b0;

    // Model outputs (what the DUT must show now) and the pending result of the frame in flight.
    logic [D-1:0] m_dout = '0;
    bit m_pe = 0, m_fe = 0, m_brk = 0, m_done = 0;
    logic [D-1:0] p_dout = '0;
    bit p_pe = 0, p_fe = 0, p_brk = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (rx_dout !== m_dout || parity_err !== m_pe || frame_err !== m_fe ||
                break_det !== m_brk || rx_done_tick !== m_done) begin
                errors++;
                $display("FAIL model t=%0t: got dout=%h pe=%b fe=%b brk=%b done=%b, expected dout=%h pe=%b fe=%b brk=%b done=%b",
                         $time, rx_dout, parity_err, frame_err, break_det, rx_done_tick,
                         m_dout, m_pe, m_fe, m_brk, m_done);
            end
            if (rx_done_tick === 1'b1) done_cnt++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One oversample period: 3..5 quiet clocks, then a single-clock s_tick.
    task automatic one_tick();
        int gap;
        gap = $urandom_range(3, 5);
        repeat (gap) begin
            @(posedge clk); #1;
            m_done = 0;
        end
        s_tick = 1'b1;
        @(posedge clk); #1;
        s_tick = 1'b0;
        m_done = 0;
        tick_no++;
        if (dec_armed && tick_no == dec_tick) begin
            dec_armed = 0;
            m_dout = p_dout;
            m_pe   = p_pe;
            m_fe   = p_fe;
            m_brk  = p_brk;
            m_done = !p_brk;
        end
    endtask

    task automatic idle_ticks(input int k);
        rx = 1'b1;
        repeat (k) one_tick();
    endtask

    // One bit slot; with noise the middle sample (s = OS/2) sees the inverted level.
    task automatic slot(input bit v, input int len, input bit noise);
        for (int j = 1; j <= len; j++) begin
            rx = (noise && j == OS / 2 + 1) ? ~v : v;
            one_tick();
        end
    endtask

    task automatic send_frame(input logic [D-1:0] data, input logic [1:0] mode, input bit two,
                              input bit par_flip, input bit st1, input bit stf, input bit noise,
                              input int stop_len, input int low_after, input int idle_after);
        bit pen, pbit;
        int nb;
        pen  = (mode == 2'b01) || (mode == 2'b10);
        pbit = (^data) ^ (mode == 2'b10) ^ par_flip;
        nb   = 1 + D + int'(pen) + int'(two);
        p_dout = data;
        p_pe   = pen && par_flip;
        p_fe   = (two && !st1) || !stf;
        p_brk  = (data == '0) && !(pen && pbit) && !stf;
        // Final stop decision falls on sample H+1 of the final stop slot.
        dec_tick  = tick_no + nb * OS + OS / 2 + 2;
        dec_armed = 1;
        cfg_parity = mode;
        cfg_stop2  = two;
        rx = 1'b0;
        one_tick();
        cfg_parity = 2'($urandom_range(0, 3));
        cfg_stop2  = 1'($urandom_range(0, 1));
        for (int j = 2; j <= OS; j++) one_tick();
        for (int i = 0; i < D; i++) slot(data[i], OS, noise);
        if (pen) slot(pbit, OS, 0);
        if (two) slot(st1, OS, 0);
        slot(stf, stop_len, 0);
        if (low_after > 0) slot(0, low_after * OS, 0);
        if (idle_after > 0) idle_ticks(idle_after);
    endtask

    int unsigned d0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;
        check("reset_dout", 32'(rx_dout), 32'h0);
        check("reset_pe", 32'(parity_err), 32'h0);
        check("reset_fe", 32'(frame_err), 32'h0);
        check("reset_brk", 32'(break_det), 32'h0);
        idle_ticks(10);

        // 8N1 0x55
        d0 = done_cnt;
        send_frame(8'h55, 2'b00, 0, 0, 1, 1, 0, OS, 0, 4);
        check("t1_dout", 32'(rx_dout), 32'h55);
        check("t1_flags", {29'd0, parity_err, frame_err, break_det}, 32'h0);
        check("t1_done_cnt", done_cnt - d0, 32'd1);

        // parity: even with bit 1 (error), even with bit 0, odd with bit 1
        send_frame(8'hA3, 2'b01, 0, 1, 1, 1, 0, OS, 0, 3);
        check("t2_even_bad_pe", 32'(parity_err), 32'h1);
        check("t2_even_bad_dout", 32'(rx_dout), 32'hA3);
        send_frame(8'hA3, 2'b01, 0, 0, 1, 1, 0, OS, 0, 3);
        check("t2_even_ok_pe", 32'(parity_err), 32'h0);
        send_frame(8'hA3, 2'b10, 0, 0, 1, 1, 0, OS, 0, 3);
        check("t2_odd_ok_pe", 32'(parity_err), 32'h0);

        // glitch: low for 4 ticks
        d0 = done_cnt;
        rx = 1'b0;
        repeat (4) one_tick();
        idle_ticks(2 * OS);
        check("t3_no_done", done_cnt - d0, 32'd0);
        check("t3_flags", {29'd0, parity_err, frame_err, break_det}, 32'h0);

        // middle-sample noise on every data bit
        send_frame(8'h3C, 2'b00, 0, 0, 1, 1, 1, OS, 0, 3);
        check("t4_dout", 32'(rx_dout), 32'h3C);

        // framing error, then break held low past the frame, then a clean frame
        d0 = done_cnt;
        send_frame(8'h81, 2'b00, 0, 0, 1, 0, 0, OS, 0, 2);
        check("t5_fe", 32'(frame_err), 32'h1);
        check("t5_fe_done", done_cnt - d0, 32'd1);
        d0 = done_cnt;
        send_frame(8'h00, 2'b00, 0, 0, 1, 0, 0, OS, 5, 4);
        check("t5_brk", {30'd0, frame_err, break_det}, 32'h3);
        check("t5_brk_no_done", done_cnt - d0, 32'd0);
        send_frame(8'h12, 2'b00, 0, 0, 1, 1, 0, OS, 0, 3);
        check("t5_after_brk", {rx_dout, 5'd0, parity_err, frame_err, break_det}, {8'h12, 8'h0});

        // back-to-back 2-stop frames
        d0 = done_cnt;
        send_frame(8'hF0, 2'b00, 1, 0, 1, 1, 0, OS, 0, 0);
        send_frame(8'h0F, 2'b00, 1, 0, 1, 1, 0, OS, 0, 3);
        check("t6_done_cnt", done_cnt - d0, 32'd2);
        check("t6_dout", 32'(rx_dout), 32'h0F);

        // reset in the middle of DATA
        d0 = done_cnt;
        cfg_parity = 2'b00;
        cfg_stop2  = 1'b0;
        slot(0, OS, 0);
        slot(1, OS, 0);
        slot(0, OS, 0);
        slot(1, OS / 2, 0);
        reset = 1'b1;
        rx    = 1'b1;
        @(posedge clk); #1;
        reset  = 1'b0;
        m_dout = '0; m_pe = 0; m_fe = 0; m_brk = 0; m_done = 0;
        check("t6_rst_dout", 32'(rx_dout), 32'h0);
        check("t6_rst_flags", {28'd0, rx_done_tick, parity_err, frame_err, break_det}, 32'h0);
        idle_ticks(2 * OS);
        check("t6_rst_no_done", done_cnt - d0, 32'd0);

        // randomized frames
        for (int k = 0; k < 30; k++) begin
            logic [D-1:0] d;
            bit stf;
            d   = D'($urandom);
            if ($urandom_range(0, 7) == 0) d = '0;
            stf = ($urandom_range(0, 5) != 0);
            send_frame(d, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) != 0), stf,
                       1'($urandom_range(0, 1)),
                       stf ? $urandom_range(OS / 2 + 3, OS) : OS, 0,
                       stf ? $urandom_range(0, 3) : $urandom_range(1, 3));
        end
        idle_ticks(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
